// File: rtl/seq_sort_calc_if.sv
// Bus bundle for seq_sort_calc.
//
// Handshake: a request transfers on a rising edge where in_valid=1 and
// in_ready=1. in_valid is ignored while in_ready=0, and requests are not
// queued. out_valid is a one-cycle strobe with no back-pressure. out_n is
// only meaningful while out_valid=1 and reads 0 otherwise.
//
// Signals:
//   in_valid            request valid (requester -> design)
//   in_n0..in_n5 [3:0]  operands
//   opt [2:0]           [0] signed operands, [1] descending, [2] weighted average
//   equ                 0: weighted product, 1: absolute difference
//   in_ready            design can accept a request (design -> requester)
//   out_valid           result strobe
//   out_n [9:0]         result
// Modports: master = requester side, slave = design side.
interface seq_sort_calc_if;
  logic       in_valid;
  logic [3:0] in_n0;
  logic [3:0] in_n1;
  logic [3:0] in_n2;
  logic [3:0] in_n3;
  logic [3:0] in_n4;
  logic [3:0] in_n5;
  logic [2:0] opt;
  logic       equ;
  logic       in_ready;
  logic       out_valid;
  logic [9:0] out_n;

  modport master (
    output in_valid, in_n0, in_n1, in_n2, in_n3, in_n4, in_n5, opt, equ,
    input  in_ready, out_valid, out_n
  );

  modport slave (
    input  in_valid, in_n0, in_n1, in_n2, in_n3, in_n4, in_n5, opt, equ,
    output in_ready, out_valid, out_n
  );
endinterface

// File: rtl/seq_sort_calc.sv
// seq_sort_calc: sequential sort / normalize / evaluate core.
//
// Captures six 4-bit operands, sorts them with odd-even transposition (one
// phase per cycle), normalizes them (subtract-minimum or chained weighted
// average), evaluates one of two equations and emits a 10-bit result with a
// one-cycle out_valid strobe.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   bus        seq_sort_calc_if.slave (request operands in, result out)
//   dbg_state  current FSM state (IDLE=0, SORT=1, NORM=2, CALC=3, OUT=4)
//
// Optional build macro: SEQ_CALC_EARLY_EXIT_EN
//   When defined, SORT leaves early once two consecutive phases made no swap
//   (the vector is then fully ordered). Results are identical either way.
module seq_sort_calc (
  input  logic                  clk,
  input  logic                  rst,
  seq_sort_calc_if.slave        bus,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SORT = 3'd1,
    S_NORM = 3'd2,
    S_CALC = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t            state;
  logic signed [4:0] n [6];
  logic              sort_desc;
  logic              norm_avg;
  logic              equ_q;
  logic [2:0]        phase;
  logic [3:0]        in_w [6];

  logic signed [4:0] n_sort [6];
  logic signed [4:0] n_norm [6];
  logic signed [6:0] prev7;
  logic signed [6:0] cur7;
  logic signed [6:0] acc7;
  logic signed [10:0] a0, a1, a3, a4, a5;
  logic signed [10:0] t_prod;
  logic signed [10:0] t_diff;

`ifdef SEQ_CALC_EARLY_EXIT_EN
  logic any_swap;
  logic prev_clean;   // previous SORT phase made no swap
`endif

  assign dbg_state = state;

  assign in_w[0] = bus.in_n0;
  assign in_w[1] = bus.in_n1;
  assign in_w[2] = bus.in_n2;
  assign in_w[3] = bus.in_n3;
  assign in_w[4] = bus.in_n4;
  assign in_w[5] = bus.in_n5;

  // One transposition phase: even phases touch pairs (0,1),(2,3),(4,5),
  // odd phases touch (1,2),(3,4). Pairs are disjoint, so reading the
  // registered values for every pair is safe.
  always_comb begin
    for (int k = 0; k < 6; k++) n_sort[k] = n[k];
`ifdef SEQ_CALC_EARLY_EXIT_EN
    any_swap = 1'b0;
`endif
    for (int i = 0; i < 5; i++) begin
      if (i[0] == phase[0]) begin
        if (sort_desc ? (n[i] < n[i+1]) : (n[i] > n[i+1])) begin
          n_sort[i]   = n[i+1];
          n_sort[i+1] = n[i];
`ifdef SEQ_CALC_EARLY_EXIT_EN
          any_swap    = 1'b1;
`endif
        end
      end
    end
  end

  // Normalization. The weighted average chains: each element uses the
  // already-updated previous element. 7-bit signed holds 2*a+b for 5-bit
  // signed a,b; the quotient always fits back into 5 bits.
  always_comb begin
    prev7 = '0;
    cur7  = '0;
    acc7  = '0;
    n_norm[0] = norm_avg ? n[0] : 5'sd0;
    for (int k = 1; k < 6; k++) begin
      if (norm_avg) begin
        prev7     = {{2{n_norm[k-1][4]}}, n_norm[k-1]};
        cur7      = {{2{n[k][4]}}, n[k]};
        acc7      = (prev7 <<< 1) + cur7;
        n_norm[k] = 5'(acc7 / 7'sd3);
      end else begin
        n_norm[k] = n[k] - n[0];
      end
    end
  end

  // Equation terms in 11-bit signed arithmetic; signed '/' truncates
  // toward zero.
  assign a0 = {{6{n[0][4]}}, n[0]};
  assign a1 = {{6{n[1][4]}}, n[1]};
  assign a3 = {{6{n[3][4]}}, n[3]};
  assign a4 = {{6{n[4][4]}}, n[4]};
  assign a5 = {{6{n[5][4]}}, n[5]};
  assign t_prod = (a3 + (a4 <<< 2)) * a5;
  assign t_diff = (a5 * a1) - (a5 * a0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_n     <= '0;
      for (int k = 0; k < 6; k++) n[k] <= '0;
      sort_desc     <= 1'b0;
      norm_avg      <= 1'b0;
      equ_q         <= 1'b0;
      phase         <= '0;
`ifdef SEQ_CALC_EARLY_EXIT_EN
      prev_clean    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            for (int k = 0; k < 6; k++)
              n[k] <= bus.opt[0] ? {in_w[k][3], in_w[k]} : {1'b0, in_w[k]};
            sort_desc    <= bus.opt[1];
            norm_avg     <= bus.opt[2];
            equ_q        <= bus.equ;
            phase        <= '0;
`ifdef SEQ_CALC_EARLY_EXIT_EN
            prev_clean   <= 1'b0;
`endif
            bus.in_ready <= 1'b0;
            state        <= S_SORT;
          end
        end
        S_SORT: begin
          for (int k = 0; k < 6; k++) n[k] <= n_sort[k];
          phase <= phase + 3'd1;
`ifdef SEQ_CALC_EARLY_EXIT_EN
          // An even and an odd phase back to back with no swap means every
          // adjacent pair is ordered.
          prev_clean <= ~any_swap;
          if ((phase == 3'd5) || (!any_swap && prev_clean)) state <= S_NORM;
`else
          if (phase == 3'd5) state <= S_NORM;
`endif
        end
        S_NORM: begin
          for (int k = 0; k < 6; k++) n[k] <= n_norm[k];
          state <= S_CALC;
        end
        S_CALC: begin
          if (equ_q) bus.out_n <= 10'((t_diff < 0) ? -t_diff : t_diff);
          else       bus.out_n <= 10'(t_prod / 11'sd3);
          bus.out_valid <= 1'b1;
          state         <= S_OUT;
        end
        S_OUT: begin
          bus.out_valid <= 1'b0;
          bus.out_n     <= '0;
          bus.in_ready  <= 1'b1;
          state         <= S_IDLE;
        end
        default: begin
          bus.out_valid <= 1'b0;
          bus.out_n     <= '0;
          bus.in_ready  <= 1'b1;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_sort_calc.sv
// Testbench for seq_sort_calc: directed requests plus a few random signed
// weighted-average requests; expected results and latency windows are
// queued at request time and checked when out_valid strobes.
module tb_seq_sort_calc;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_sort_calc_if bus ();
  logic [2:0] dbg_state;

  seq_sort_calc dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

`ifdef SEQ_CALC_EARLY_EXIT_EN
  localparam int MIN_LAT = 4;
`else
  localparam int MIN_LAT = 8;
`endif
  localparam int MAX_LAT = 8;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [9:0] exp_q[$];
  int         lo_q[$];
  int         hi_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          logic [9:0] e;
          int lo, hi;
          e  = exp_q.pop_front();
          lo = lo_q.pop_front();
          hi = hi_q.pop_front();
          check("out_n", {22'd0, bus.out_n}, {22'd0, e});
          if (lo == hi) check("latency", cyc, lo);
          else          check("latency_window", (cyc >= lo && cyc <= hi), 1);
        end
      end else begin
        check("out_n_zero_when_idle", {22'd0, bus.out_n}, 32'd0);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [9:0] model(input logic [3:0] v[6], input logic [2:0] o, input logic e);
    int a[6];
    int t, r, s;
    for (int i = 0; i < 6; i++)
      a[i] = (o[0] && v[i][3]) ? int'(v[i]) - 16 : int'(v[i]);
    for (int p = 0; p < 6; p++)
      for (int j = 0; j < 5; j++)
        if (o[1] ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
          s = a[j]; a[j] = a[j+1]; a[j+1] = s;
        end
    if (o[2]) begin
      for (int k = 1; k < 6; k++) a[k] = (2 * a[k-1] + a[k]) / 3;
    end else begin
      for (int k = 1; k < 6; k++) a[k] = a[k] - a[0];
      a[0] = 0;
    end
    if (!e) r = ((a[3] + 4 * a[4]) * a[5]) / 3;
    else begin
      t = a[5] * a[1] - a[5] * a[0];
      r = (t < 0) ? -t : t;
    end
    return r[9:0];
  endfunction

  // ---------------- driver ----------------
  task automatic drive_ops(input logic [3:0] v[6], input logic [2:0] o, input logic e);
    bus.in_n0 = v[0]; bus.in_n1 = v[1]; bus.in_n2 = v[2];
    bus.in_n3 = v[3]; bus.in_n4 = v[4]; bus.in_n5 = v[5];
    bus.opt   = o;
    bus.equ   = e;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [3:0] v[6], input logic [2:0] o, input logic e,
                      input logic [9:0] expv, input int min_lat, input int max_lat);
    int waited = 0;
    while (!bus.in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_before_send", {31'd0, bus.in_ready}, 32'd1);
    drive_ops(v, o, e);
    bus.in_valid = 1'b1;
    exp_q.push_back(expv);
    lo_q.push_back(cyc + 1 + min_lat);
    hi_q.push_back(cyc + 1 + max_lat);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("in_ready_low_after_accept", {31'd0, bus.in_ready}, 32'd0);
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("drain_results", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [3:0] ops[6];
    logic [3:0] alt[6];
    logic [2:0] o;
    logic       e;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    ops = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    drive_ops(ops, 3'b000, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_out_n", {22'd0, bus.out_n}, 32'd0);
    check("reset_state", {29'd0, dbg_state}, 32'd0);

    // Unsigned ascending, weighted product.
    ops = '{4'd3, 4'd9, 4'd1, 4'd7, 4'd0, 4'd5};
    send(ops, 3'b000, 1'b0, 10'd99, MIN_LAT, MAX_LAT);
    drain();

    // Descending, subtract-minimum, absolute difference.
    send(ops, 3'b010, 1'b1, 10'd18, MIN_LAT, MAX_LAT);
    drain();

    // Signed ascending, weighted average, absolute difference.
    ops = '{4'hF, 4'h2, 4'h8, 4'h7, 4'h0, 4'h3};
    send(ops, 3'b101, 1'b1, 10'd6, MIN_LAT, MAX_LAT);
    drain();

    // Pre-sorted input: shortest SORT when early exit is built in.
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    send(ops, 3'b000, 1'b0, 10'd31, MIN_LAT, MIN_LAT);
    drain();

    // Back-to-back requests: second accepted right after OUT.
    ops = '{4'd3, 4'd9, 4'd1, 4'd7, 4'd0, 4'd5};
    send(ops, 3'b000, 1'b0, 10'd99, MIN_LAT, MAX_LAT);
    ops = '{4'hF, 4'h2, 4'h8, 4'h7, 4'h0, 4'h3};
    send(ops, 3'b101, 1'b1, 10'd6, MIN_LAT, MAX_LAT);
    drain();

    // in_valid pulse with other operands during SORT is ignored.
    ops = '{4'd3, 4'd9, 4'd1, 4'd7, 4'd0, 4'd5};
    send(ops, 3'b000, 1'b0, 10'd99, MIN_LAT, MAX_LAT);
    @(negedge clk);
    alt = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
    drive_ops(alt, 3'b010, 1'b1);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    drain();
    repeat (12) @(negedge clk);

    // Reset at edge E+3 aborts the request without a result.
    ops = '{4'd8, 4'd2, 4'd6, 4'd1, 4'd4, 4'd3};
    drive_ops(ops, 3'b000, 1'b0);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort_state", {29'd0, dbg_state}, 32'd0);
    repeat (12) @(negedge clk);
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    send(ops, 3'b000, 1'b0, 10'd31, MIN_LAT, MIN_LAT);
    drain();

    // rst and in_valid together: nothing captured.
    ops = '{4'd3, 4'd9, 4'd1, 4'd7, 4'd0, 4'd5};
    drive_ops(ops, 3'b000, 1'b0);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("rst_wins_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_wins_state", {29'd0, dbg_state}, 32'd0);
    repeat (12) @(negedge clk);

    // Random signed weighted-average requests (range stays within 10 bits).
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 6; k++) ops[k] = 4'($urandom_range(0, 15));
      o = {1'b1, 1'($urandom_range(0, 1)), 1'b1};
      e = 1'($urandom_range(0, 1));
      send(ops, o, e, model(ops, o, e), MIN_LAT, MAX_LAT);
    end
    drain();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_sort_calc.md
# seq_sort_calc

- Sequential, handshaked implementation of the Lab01 sort/normalize/evaluate function.
- Accepts six 4-bit operands plus an opcode in one cycle and sorts them serially with odd-even transposition.
- Normalizes the sorted values, evaluates the selected equation, and returns a 10-bit result with a one-cycle valid pulse.
- It is the design-side responder to the Lab01 stimulus/checker bench, and the multi-cycle core for later labs.

## Interface
Parameters:
- none; widths are fixed by the protocol.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/opcode valid; sampled only when in_ready=1.
- in_n0..in_n5  in  4 each  operands.
- opt  in  3  [0] signed operands, [1] descending sort, [2] weighted-average normalization.
- equ  in  1  0: weighted product equation; 1: absolute-difference equation.
- in_ready  out  1  high only in IDLE.
- out_valid  out  1  one-cycle result strobe.
- out_n  out  10  result; forced to 0 whenever out_valid=0.

## Operation
- FSM states: IDLE, SORT, NORM, CALC, OUT.
- **IDLE**
  - in_ready=1.
  - in_valid=1 at an edge captures the operands, each extended to 5-bit signed: sign-extended if opt[0]=1, zero-extended otherwise.
  - Captures opt and equ.
  - Clears the phase counter and moves to SORT.
- **SORT**
  - One phase per cycle.
  - Even phase compares pairs (0,1),(2,3),(4,5); odd phase compares (1,2),(3,4).
  - A pair swaps when out of order: ascending if opt[1]=0, descending if opt[1]=1.
  - Phase counter 0..5; after phase 5 go to NORM.
- **NORM**, single cycle, result written back to the operand registers:
  - opt[2]=0: n[k]=n[k]-n[0] for k=1..5, then n[0]=0. 5-bit signed, cannot overflow for legal inputs.
  - opt[2]=1: chained weighted average n[k]=(2·n'[k-1]+n[k])/3 for k=1..5, where n'[k-1] is the new value.
    - n[0] is unchanged.
    - Division is signed and truncates toward zero; the result is 5-bit signed.
- **CALC**
  - Evaluated in 11-bit signed arithmetic.
  - equ=0: ((n3+4·n4)·n5)/3, truncated toward zero.
  - equ=1: |n5·n1 − n5·n0|.
  - Low 10 bits registered into out_n; out_valid set; go to OUT.
- **OUT**
  - out_valid=1 for exactly this cycle, then out_valid=0, out_n=0, back to IDLE.
- in_valid asserted outside IDLE is ignored; there is no queueing.
- A new request may be accepted in the cycle immediately after OUT, since IDLE has in_ready=1.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_n=0. All operand registers and counters cleared.
- rst=1 in any state aborts the operation next edge; no out_valid for the aborted request.
- Latency without the macro is fixed.
  - in_valid sampled at edge E; SORT occupies edges E+1..E+6, NORM E+7, CALC E+8.
  - out_valid is high in the cycle after edge E+8.
  - in_ready is low from E+1 until the return to IDLE.
- Throughput without the macro: one result per 10 cycles.
- rst and in_valid asserted in the same cycle: rst wins and nothing is captured.

## Configuration
- Macro: SEQ_CALC_EARLY_EXIT_EN.
- Defined:
  - SORT tracks a per-phase swap flag.
  - SORT exits to NORM after two consecutive phases with no swap, or after phase 5, whichever comes first.
  - Minimum SORT length is 2 cycles, so the minimum latency is out_valid after edge E+4.
  - Results are identical to the macro-off build.
- Undefined: SORT always runs 6 phases; swap-flag logic is absent.

## Test plan
- Reset behaviour: assert rst for 2 cycles -> in_ready=1, out_valid=0, out_n=0.
- Basic unsigned ascending, equ=0: in_n=3,9,1,7,0,5, opt=000, equ=0 -> out_n=99, out_valid after edge E+8.
- Same operands, opt=010, equ=1 -> descending order, subtract n0, out_n=18.
- Signed ascending with weighted average: in_n=F,2,8,7,0,3, opt=101, equ=1 -> sorted −8,−1,0,2,3,7; averages −8,−5,−3,−1,0,2; out_n=6.
- Pre-sorted input 0,1,2,3,4,5, opt=000, equ=0 -> out_n=31.
  - With SEQ_CALC_EARLY_EXIT_EN: out_valid after edge E+4.
  - Without it: out_valid after edge E+8.
- Robustness:
  - Pulse in_valid with new operands during SORT -> ignored, first result unchanged.
  - Assert rst at edge E+3 -> no out_valid; a following request completes correctly.
